// File: rtl/wired_axi_arb.sv
// Shares one AXI host port between NUM_MST requesters with independent round-robin
// read and write arbitration, one outstanding transaction per direction.
module wired_axi_arb #(
  parameter int unsigned NUM_MST = 2,
  parameter int unsigned ID_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // master side: read address / read data
  input  logic [NUM_MST-1:0]      m_ar_valid,
  output logic [NUM_MST-1:0]      m_ar_ready,
  input  logic [NUM_MST*ID_W-1:0] m_ar_id,
  input  logic [NUM_MST*32-1:0]   m_ar_addr,
  input  logic [NUM_MST*8-1:0]    m_ar_len,
  input  logic [NUM_MST*3-1:0]    m_ar_size,
  input  logic [NUM_MST*2-1:0]    m_ar_burst,
  input  logic [NUM_MST*4-1:0]    m_ar_cache,
  input  logic [NUM_MST*3-1:0]    m_ar_prot,
  output logic [NUM_MST-1:0]      m_r_valid,
  input  logic [NUM_MST-1:0]      m_r_ready,
  output logic [ID_W-1:0]         m_r_id,
  output logic [31:0]             m_r_data,
  output logic [1:0]              m_r_resp,
  output logic                    m_r_last,
  // master side: write address / data / response
  input  logic [NUM_MST-1:0]      m_aw_valid,
  output logic [NUM_MST-1:0]      m_aw_ready,
  input  logic [NUM_MST*ID_W-1:0] m_aw_id,
  input  logic [NUM_MST*32-1:0]   m_aw_addr,
  input  logic [NUM_MST*8-1:0]    m_aw_len,
  input  logic [NUM_MST*3-1:0]    m_aw_size,
  input  logic [NUM_MST*2-1:0]    m_aw_burst,
  input  logic [NUM_MST*4-1:0]    m_aw_cache,
  input  logic [NUM_MST*3-1:0]    m_aw_prot,
  input  logic [NUM_MST-1:0]      m_w_valid,
  output logic [NUM_MST-1:0]      m_w_ready,
  input  logic [NUM_MST*32-1:0]   m_w_data,
  input  logic [NUM_MST*4-1:0]    m_w_strb,
  input  logic [NUM_MST-1:0]      m_w_last,
  output logic [NUM_MST-1:0]      m_b_valid,
  input  logic [NUM_MST-1:0]      m_b_ready,
  output logic [ID_W-1:0]         m_b_id,
  output logic [1:0]              m_b_resp,
  // downstream host port
  output logic                    s_ar_valid,
  input  logic                    s_ar_ready,
  output logic [ID_W-1:0]         s_ar_id,
  output logic [31:0]             s_ar_addr,
  output logic [7:0]              s_ar_len,
  output logic [2:0]              s_ar_size,
  output logic [1:0]              s_ar_burst,
  output logic [3:0]              s_ar_cache,
  output logic [2:0]              s_ar_prot,
  output logic                    s_ar_lock,
  input  logic                    s_r_valid,
  output logic                    s_r_ready,
  input  logic [ID_W-1:0]         s_r_id,
  input  logic [31:0]             s_r_data,
  input  logic [1:0]              s_r_resp,
  input  logic                    s_r_last,
  output logic                    s_aw_valid,
  input  logic                    s_aw_ready,
  output logic [ID_W-1:0]         s_aw_id,
  output logic [31:0]             s_aw_addr,
  output logic [7:0]              s_aw_len,
  output logic [2:0]              s_aw_size,
  output logic [1:0]              s_aw_burst,
  output logic [3:0]              s_aw_cache,
  output logic [2:0]              s_aw_prot,
  output logic                    s_aw_lock,
  output logic                    s_w_valid,
  input  logic                    s_w_ready,
  output logic [31:0]             s_w_data,
  output logic [3:0]              s_w_strb,
  output logic                    s_w_last,
  input  logic                    s_b_valid,
  output logic                    s_b_ready,
  input  logic [ID_W-1:0]         s_b_id,
  input  logic [1:0]              s_b_resp
);

  localparam int unsigned GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [3:0]      cache;
    logic [2:0]      prot;
  } ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  r_state_t      r_state, r_state_nxt;
  w_state_t      w_state, w_state_nxt;
  logic [GW-1:0] rg, rg_nxt, rptr, rptr_nxt;
  logic [GW-1:0] wg, wg_nxt, wptr, wptr_nxt;

  ax_t ar_a [NUM_MST];
  ax_t aw_a [NUM_MST];
  w_t  w_a  [NUM_MST];
  ax_t ar_sel, aw_sel;
  w_t  w_sel;

  // Unpack the flat per-master payload buses into indexable records
  for (genvar g = 0; g < NUM_MST; g++) begin : g_slice
    assign ar_a[g] = '{id:    m_ar_id[g*ID_W +: ID_W],
                       addr:  m_ar_addr[g*32 +: 32],
                       len:   m_ar_len[g*8 +: 8],
                       size:  m_ar_size[g*3 +: 3],
                       burst: m_ar_burst[g*2 +: 2],
                       cache: m_ar_cache[g*4 +: 4],
                       prot:  m_ar_prot[g*3 +: 3]};
    assign aw_a[g] = '{id:    m_aw_id[g*ID_W +: ID_W],
                       addr:  m_aw_addr[g*32 +: 32],
                       len:   m_aw_len[g*8 +: 8],
                       size:  m_aw_size[g*3 +: 3],
                       burst: m_aw_burst[g*2 +: 2],
                       cache: m_aw_cache[g*4 +: 4],
                       prot:  m_aw_prot[g*3 +: 3]};
    assign w_a[g]  = '{data: m_w_data[g*32 +: 32],
                       strb: m_w_strb[g*4 +: 4],
                       last: m_w_last[g]};
  end

  // First requester at or after ptr, in cyclic order
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                            input logic [GW-1:0]      ptr);
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          found;
    int unsigned   idx_n;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      idx_n = 32'(ptr) + i;
      if (idx_n >= NUM_MST) idx_n = idx_n - NUM_MST;
      idx = GW'(idx_n);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [GW-1:0] ptr_after(input logic [GW-1:0] g);
    return (32'(g) + 32'd1 >= NUM_MST) ? '0 : g + GW'(1);
  endfunction

  // Payload forwarding is a pure mux on the registered grant
  assign ar_sel     = ar_a[rg];
  assign aw_sel     = aw_a[wg];
  assign w_sel      = w_a[wg];

  assign s_ar_id    = ar_sel.id;
  assign s_ar_addr  = ar_sel.addr;
  assign s_ar_len   = ar_sel.len;
  assign s_ar_size  = ar_sel.size;
  assign s_ar_burst = ar_sel.burst;
  assign s_ar_cache = ar_sel.cache;
  assign s_ar_prot  = ar_sel.prot;
  assign s_ar_lock  = 1'b0;

  assign s_aw_id    = aw_sel.id;
  assign s_aw_addr  = aw_sel.addr;
  assign s_aw_len   = aw_sel.len;
  assign s_aw_size  = aw_sel.size;
  assign s_aw_burst = aw_sel.burst;
  assign s_aw_cache = aw_sel.cache;
  assign s_aw_prot  = aw_sel.prot;
  assign s_aw_lock  = 1'b0;

  assign s_w_data   = w_sel.data;
  assign s_w_strb   = w_sel.strb;
  assign s_w_last   = w_sel.last;

  assign m_r_id     = s_r_id;
  assign m_r_data   = s_r_data;
  assign m_r_resp   = s_r_resp;
  assign m_r_last   = s_r_last;
  assign m_b_id     = s_b_id;
  assign m_b_resp   = s_b_resp;

  // Read direction state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rg      <= '0;
      rptr    <= '0;
    end else begin
      r_state <= r_state_nxt;
      rg      <= rg_nxt;
      rptr    <= rptr_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    rg_nxt      = rg;
    rptr_nxt    = rptr;
    s_ar_valid  = 1'b0;
    m_ar_ready  = '0;
    m_r_valid   = '0;
    s_r_ready   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (|m_ar_valid) begin
          rg_nxt      = rr_pick(m_ar_valid, rptr);
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        s_ar_valid     = m_ar_valid[rg];
        m_ar_ready[rg] = s_ar_ready;
        if (m_ar_valid[rg] && s_ar_ready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        m_r_valid[rg] = s_r_valid;
        s_r_ready     = m_r_ready[rg];
        if (s_r_valid && m_r_ready[rg] && s_r_last) begin
          rptr_nxt    = ptr_after(rg);
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Write direction state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      wg      <= '0;
      wptr    <= '0;
    end else begin
      w_state <= w_state_nxt;
      wg      <= wg_nxt;
      wptr    <= wptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    wg_nxt      = wg;
    wptr_nxt    = wptr;
    s_aw_valid  = 1'b0;
    m_aw_ready  = '0;
    s_w_valid   = 1'b0;
    m_w_ready   = '0;
    m_b_valid   = '0;
    s_b_ready   = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (|m_aw_valid) begin
          wg_nxt      = rr_pick(m_aw_valid, wptr);
          w_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        s_aw_valid     = m_aw_valid[wg];
        m_aw_ready[wg] = s_aw_ready;
        if (m_aw_valid[wg] && s_aw_ready) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_w_valid     = m_w_valid[wg];
        m_w_ready[wg] = s_w_ready;
        if (m_w_valid[wg] && s_w_ready && w_sel.last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        m_b_valid[wg] = s_b_valid;
        s_b_ready     = m_b_ready[wg];
        if (s_b_valid && m_b_ready[wg]) begin
          wptr_nxt    = ptr_after(wg);
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wired_axi_arb.sv
// Directed bench for wired_axi_arb: read-path vector table, then hand-written
// concurrent, error-response, backpressure and mid-burst reset sequences.
module tb_wired_axi_arb;

  localparam int unsigned N  = 2;
  localparam int unsigned IW = 4;
  localparam logic [31:0] A0  = 32'h1c00_0000;
  localparam logic [31:0] A1  = 32'h2000_0000;
  localparam logic [31:0] AW0 = 32'h1c00_0100;
  localparam logic [31:0] AW1 = 32'h3000_0040;

  logic clk, rst_n;
  logic [N-1:0]    m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [N*IW-1:0] m_ar_id, m_aw_id;
  logic [N*32-1:0] m_ar_addr, m_aw_addr, m_w_data;
  logic [N*8-1:0]  m_ar_len, m_aw_len;
  logic [N*3-1:0]  m_ar_size, m_ar_prot, m_aw_size, m_aw_prot;
  logic [N*2-1:0]  m_ar_burst, m_aw_burst;
  logic [N*4-1:0]  m_ar_cache, m_aw_cache, m_w_strb;
  logic [IW-1:0]   m_r_id, m_b_id;
  logic [31:0]     m_r_data;
  logic [1:0]      m_r_resp, m_b_resp;
  logic            m_r_last;
  logic [N-1:0]    m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last;
  logic [N-1:0]    m_b_valid, m_b_ready;
  logic            s_ar_valid, s_ar_ready, s_ar_lock, s_r_valid, s_r_ready, s_r_last;
  logic [IW-1:0]   s_ar_id, s_aw_id, s_r_id, s_b_id;
  logic [31:0]     s_ar_addr, s_aw_addr, s_r_data, s_w_data;
  logic [7:0]      s_ar_len, s_aw_len;
  logic [2:0]      s_ar_size, s_ar_prot, s_aw_size, s_aw_prot;
  logic [1:0]      s_ar_burst, s_aw_burst, s_r_resp, s_b_resp;
  logic [3:0]      s_ar_cache, s_aw_cache, s_w_strb;
  logic            s_aw_valid, s_aw_ready, s_aw_lock, s_w_valid, s_w_ready, s_w_last;
  logic            s_b_valid, s_b_ready;

  int checks = 0;
  int errors = 0;

  wired_axi_arb #(.NUM_MST(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id),
    .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_burst(m_aw_burst), .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot),
    .s_ar_lock(s_ar_lock),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
    .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_burst(s_aw_burst), .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot),
    .s_aw_lock(s_aw_lock),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ar_valid;
    logic [1:0]  r_ready;
    logic        ar_ready;
    logic        r_valid;
    logic        r_last;
    logic        e_s_ar_valid;
    logic [1:0]  e_ar_ready;
    logic [1:0]  e_r_valid;
    logic        e_s_r_ready;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t v(input logic [1:0] av, input logic [1:0] rr, input logic ar,
                             input logic rv, input logic rl, input logic es,
                             input logic [1:0] ear, input logic [1:0] erv,
                             input logic esr, input logic [31:0] ea);
    return '{av, rr, ar, rv, rl, es, ear, erv, esr, ea};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_vr();
    return 32'({s_ar_valid, m_ar_ready, m_r_valid, s_r_ready, s_aw_valid, m_aw_ready,
                s_w_valid, m_w_ready, m_b_valid, s_b_ready});
  endfunction

  task automatic clr_inputs();
    m_ar_valid = '0; m_r_ready = '0; m_aw_valid = '0; m_w_valid = '0; m_b_ready = '0;
    m_w_last = '0; s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_last = 1'b0;
    s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ref_mem [4];
  logic [31:0] wdat [4];

  initial begin
    int ga, gs, gm, gw, sent, got, wi, ws;
    logic ar_done, aw_done, b_done;

    m_ar_id = {4'h5, 4'h3}; m_ar_addr = {A1, A0}; m_ar_len = {8'd0, 8'd3};
    m_ar_size = {3'd2, 3'd2}; m_ar_burst = {2'b01, 2'b01}; m_ar_cache = '0; m_ar_prot = '0;
    m_aw_id = {4'h6, 4'h2}; m_aw_addr = {AW1, AW0}; m_aw_len = {8'd3, 8'd1};
    m_aw_size = {3'd2, 3'd2}; m_aw_burst = {2'b01, 2'b01}; m_aw_cache = '0; m_aw_prot = '0;
    m_w_data = '0; m_w_strb = '1; s_r_id = 4'h3; s_r_data = '0; s_r_resp = 2'b00;
    s_b_id = '0; s_b_resp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
      wdat[i]    = 32'hBEEF_0000 + 32'(i) * 32'h0000_0101;
    end

    // reset: every valid/ready is 0 even with all inputs asserted
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) next_cyc();
    m_ar_valid = 2'b11; m_aw_valid = 2'b11; m_w_valid = 2'b11; m_r_ready = 2'b11;
    m_b_ready = 2'b11; s_ar_ready = 1'b1; s_aw_ready = 1'b1; s_w_ready = 1'b1;
    s_r_valid = 1'b1; s_b_valid = 1'b1;
    #4 chk("reset_vr", all_vr(), 32'h0);
    next_cyc();
    rst_n = 1'b1;
    clr_inputs();

    //              av     rr     ar    rv    rl    es    ear    erv    esr   addr
    tbl[0]  = v(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    tbl[1]  = v(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    tbl[2]  = v(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, A0);
    tbl[3]  = v(2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0);
    tbl[4]  = v(2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0);
    tbl[5]  = v(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0);
    tbl[6]  = v(2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0);
    tbl[7]  = v(2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0);
    tbl[8]  = v(2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    tbl[9]  = v(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    tbl[10] = v(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, A1);
    tbl[11] = v(2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 32'h0);
    tbl[12] = v(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    tbl[13] = v(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, A0);
    tbl[14] = v(2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0);
    tbl[15] = v(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
    tbl[16] = v(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, A1);
    tbl[17] = v(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 32'h0);
    tbl[18] = v(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, A1);
    tbl[19] = v(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0);
    tbl[20] = v(2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 32'h0);
    tbl[21] = v(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);

    for (int i = 0; i < 22; i++) begin
      m_ar_valid = tbl[i].ar_valid; m_r_ready = tbl[i].r_ready; s_ar_ready = tbl[i].ar_ready;
      s_r_valid = tbl[i].r_valid; s_r_last = tbl[i].r_last;
      #4;
      chk($sformatf("v%0d_s_ar_valid", i), s_ar_valid, tbl[i].e_s_ar_valid);
      chk($sformatf("v%0d_m_ar_ready", i), m_ar_ready, tbl[i].e_ar_ready);
      chk($sformatf("v%0d_m_r_valid", i), m_r_valid, tbl[i].e_r_valid);
      chk($sformatf("v%0d_s_r_ready", i), s_r_ready, tbl[i].e_s_r_ready);
      if (tbl[i].e_s_ar_valid) chk($sformatf("v%0d_s_ar_addr", i), s_ar_addr, tbl[i].e_addr);
      next_cyc();
    end
    clr_inputs();

    // concurrent: master 1 reads while master 0 writes two beats, slave answers SLVERR
    m_ar_valid = 2'b10; m_aw_valid = 2'b01;
    #4 chk("cc_idle", all_vr(), 32'h0);
    next_cyc();
    s_ar_ready = 1'b1; s_aw_ready = 1'b1;
    #4;
    chk("cc_s_ar_valid", s_ar_valid, 1'b1); chk("cc_m_ar_ready", m_ar_ready, 2'b10);
    chk("cc_s_ar_addr", s_ar_addr, A1);     chk("cc_s_aw_valid", s_aw_valid, 1'b1);
    chk("cc_m_aw_ready", m_aw_ready, 2'b01); chk("cc_s_aw_addr", s_aw_addr, AW0);
    chk("cc_s_aw_len", s_aw_len, 8'd1);     chk("cc_aw_lock", s_aw_lock, 1'b0);
    next_cyc();
    m_ar_valid = '0; m_aw_valid = '0; s_ar_ready = 1'b0; s_aw_ready = 1'b0;
    m_w_valid = 2'b01; m_w_data = {32'h0, 32'hA5A5_0001}; m_w_strb = 8'h0F; m_w_last = 2'b00;
    s_w_ready = 1'b1; s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 32'h0000_1234;
    m_r_ready = 2'b11;
    #4;
    chk("cc_m_r_valid", m_r_valid, 2'b10); chk("cc_s_r_ready", s_r_ready, 1'b1);
    chk("cc_m_r_data", m_r_data, 32'h0000_1234); chk("cc_s_w_valid", s_w_valid, 1'b1);
    chk("cc_m_w_ready", m_w_ready, 2'b01); chk("cc_s_w_data0", s_w_data, 32'hA5A5_0001);
    chk("cc_s_w_strb", s_w_strb, 4'hF);  chk("cc_s_w_last0", s_w_last, 1'b0);
    next_cyc();
    s_r_valid = 1'b0; m_w_data = {32'h0, 32'hA5A5_0002}; m_w_last = 2'b01;
    #4;
    chk("cc_r_done", m_r_valid, 2'b00); chk("cc_s_w_data1", s_w_data, 32'hA5A5_0002);
    chk("cc_s_w_last1", s_w_last, 1'b1); chk("cc_b_early", m_b_valid, 2'b00);
    next_cyc();
    m_w_valid = '0; m_w_last = '0; s_w_ready = 1'b0;
    s_b_valid = 1'b1; s_b_resp = 2'b10; s_b_id = 4'h7; m_b_ready = 2'b11;
    #4;
    chk("cc_m_b_valid", m_b_valid, 2'b01); chk("cc_s_b_ready", s_b_ready, 1'b1);
    chk("cc_m_b_resp", m_b_resp, 2'b10);   chk("cc_m_b_id", m_b_id, 4'h7);
    chk("cc_w_idle", s_w_valid, 1'b0);
    next_cyc();
    s_b_valid = 1'b0; s_b_resp = 2'b00; m_aw_valid = 2'b11;
    #4 chk("cc_w_back_idle", all_vr(), 32'h0);
    next_cyc();
    #4;
    chk("wptr_adv_aw_valid", s_aw_valid, 1'b1);
    chk("wptr_adv_aw_addr", s_aw_addr, AW1);
    chk("wptr_adv_aw_ready", m_aw_ready, 2'b00);
    next_cyc();

    // write backpressure: master 1 writes 4 beats, s_aw_ready/s_w_ready gapped
    aw_done = 1'b0; b_done = 1'b0; wi = 0; ws = 0;
    ga = int'($urandom_range(0, 5)); gw = int'($urandom_range(0, 5));
    m_w_strb = 8'hF0; m_b_ready = 2'b10;
    for (int cyc = 0; cyc < 300 && !b_done; cyc++) begin
      m_aw_valid = aw_done ? 2'b00 : 2'b10;
      s_aw_ready = (ga == 0);
      m_w_valid = (wi < 4) ? 2'b10 : 2'b00;
      m_w_data = {wdat[wi % 4], 32'h0};
      m_w_last = (wi == 3) ? 2'b10 : 2'b00;
      s_w_ready = (gw == 0);
      s_b_valid = (ws == 4);
      #4;
      chk("bp_w_ready0", m_w_ready[0], 1'b0);
      chk("bp_b_valid0", m_b_valid[0], 1'b0);
      if (s_aw_valid && s_aw_ready) begin
        aw_done = 1'b1;
        chk("bp_aw_addr", s_aw_addr, AW1);
      end else if (ga > 0) ga--;
      if (s_w_valid && s_w_ready) begin
        chk("bp_w_data", s_w_data, wdat[ws % 4]);
        chk("bp_w_last", s_w_last, 32'(ws == 3));
        chk("bp_w_strb", s_w_strb, 4'hF);
        ws++;
        gw = int'($urandom_range(0, 5));
      end else if (gw > 0) gw--;
      if (m_w_valid[1] && m_w_ready[1]) wi++;
      if (m_b_valid[1] && m_b_ready[1]) b_done = 1'b1;
      next_cyc();
    end
    chk("bp_w_complete", b_done, 1'b1);
    chk("bp_w_beats", 32'(ws), 32'd4);
    clr_inputs();

    // read backpressure: master 0 reads 4 beats from the reference memory
    ar_done = 1'b0; sent = 0; got = 0;
    ga = int'($urandom_range(0, 5)); gs = int'($urandom_range(0, 5));
    gm = int'($urandom_range(0, 5));
    for (int cyc = 0; cyc < 300 && got < 4; cyc++) begin
      m_ar_valid = ar_done ? 2'b00 : 2'b01;
      s_ar_ready = (ga == 0);
      s_r_valid = ar_done && sent < 4 && gs == 0;
      s_r_data = ref_mem[sent % 4];
      s_r_last = (sent == 3);
      m_r_ready = (gm == 0) ? 2'b01 : 2'b00;
      #4;
      chk("bp_r_valid1", m_r_valid[1], 1'b0);
      if (s_ar_valid && s_ar_ready) ar_done = 1'b1;
      else if (ga > 0) ga--;
      if (m_r_valid[0] && m_r_ready[0]) begin
        chk("bp_r_data", m_r_data, ref_mem[got % 4]);
        chk("bp_r_last", m_r_last, 32'(got == 3));
        got++;
        gm = int'($urandom_range(0, 5));
      end else if (gm > 0) gm--;
      if (s_r_valid && s_r_ready) begin
        sent++;
        gs = int'($urandom_range(0, 5));
      end else if (gs > 0) gs--;
      next_cyc();
    end
    chk("bp_r_complete", 32'(got), 32'd4);
    chk("bp_r_no_dup", 32'(sent), 32'(got));
    clr_inputs();
    #4 chk("bp_r_idle", all_vr(), 32'h0);
    next_cyc();

    // reset asserted during beat 2 of a 4-beat read by master 0
    m_ar_valid = 2'b01; s_ar_ready = 1'b1;
    next_cyc();
    next_cyc();
    m_ar_valid = '0; s_ar_ready = 1'b0; s_r_valid = 1'b1; s_r_last = 1'b0; m_r_ready = 2'b01;
    #4 chk("rst_beat1", m_r_valid, 2'b01);
    next_cyc();
    rst_n = 1'b0;
    #4 chk("rst_beat2", m_r_valid, 2'b01);
    next_cyc();
    m_ar_valid = 2'b11; m_aw_valid = 2'b11; m_w_valid = 2'b11; m_r_ready = 2'b11;
    m_b_ready = 2'b11; s_ar_ready = 1'b1; s_aw_ready = 1'b1; s_w_ready = 1'b1;
    s_b_valid = 1'b1;
    #4 chk("rst_mid_vr", all_vr(), 32'h0);
    next_cyc();
    rst_n = 1'b1;
    clr_inputs();
    m_ar_valid = 2'b11; s_ar_ready = 1'b1;
    next_cyc();
    #4;
    chk("rst_rptr_addr", s_ar_addr, A0);
    chk("rst_rptr_ready", m_ar_ready, 2'b01);
    next_cyc();
    clr_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wired_axi_arb.md
# wired_axi_arb

Shares the single 32-bit AXI memory port of `wired_sp` between `NUM_MST` internal requesters (instruction fetch, data cache refill/writeback, uncached access). Read and write directions are arbitrated independently with round-robin priority. Each direction allows one outstanding transaction, and responses are steered back to the granted master. The block sits between the core's cache/bus units and the top-level AXI host port.

## Interface
- `NUM_MST`, 2: number of requesting masters, at least 1.
- `ID_W`, 4: AXI id width, passed through unchanged.
- `clk  in  1`: single clock for all logic.
- `rst_n  in  1`: reset, synchronous, active-low.
- `m_ar_valid  in  NUM_MST`: per-master read-address valid.
- `m_ar_ready  out  NUM_MST`: per-master read-address ready.
- `m_ar_{id,addr,len,size,burst,cache,prot}  in  NUM_MST×{ID_W,32,8,3,2,4,3}`: packed per-master AR payload; master i occupies slice i.
- `m_r_valid  out  NUM_MST`: per-master read-data valid.
- `m_r_ready  in  NUM_MST`: per-master read-data ready.
- `m_r_{id,data,resp,last}  out  ID_W,32,2,1`: R payload, broadcast to all masters.
- `m_aw_valid  in  NUM_MST`, `m_aw_ready  out  NUM_MST`, `m_aw_{…}  in`: write-address channel; same fields and packing as AR.
- `m_w_valid  in  NUM_MST`, `m_w_ready  out  NUM_MST`, `m_w_{data,strb,last}  in  NUM_MST×{32,4,1}`: per-master write data.
- `m_b_valid  out  NUM_MST`, `m_b_ready  in  NUM_MST`, `m_b_{id,resp}  out  ID_W,2`: write response, broadcast payload.
- `s_ar_*`, `s_r_*`, `s_aw_*`, `s_w_*`, `s_b_*`: single downstream AXI host port, same fields. `s_*_lock` is driven to 0.

## Operation
- **Read FSM states:** R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any `m_ar_valid`, register grant `rg` = first requester at or after `rptr` (cyclic order), then go to R_ADDR.
  - R_ADDR: `s_ar_valid = m_ar_valid[rg]`; `s_ar_*` = slice `rg`; `m_ar_ready[rg] = s_ar_ready`. On the `s_ar` handshake, go to R_DATA.
  - R_DATA: `m_r_valid[rg] = s_r_valid`; `s_r_ready = m_r_ready[rg]`; R payload passed through. On an R handshake with `last`, set `rptr = (rg+1) mod NUM_MST` and go to R_IDLE.
- **Write FSM states:** W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE and W_ADDR: as for reads, using `wg` and `wptr`.
  - W_DATA: `s_w_valid = m_w_valid[wg]`; `m_w_ready[wg] = s_w_ready`. On a W handshake with `last`, go to W_RESP.
  - W_RESP: `m_b_valid[wg] = s_b_valid`; `s_b_ready = m_b_ready[wg]`. On the B handshake, advance `wptr` and go to W_IDLE.
- Non-granted masters see ready and valid held at 0 on every channel.
- Read and write FSMs are fully independent; concurrent read and write are allowed.
- `resp` values, including SLVERR/DECERR, are forwarded unmodified. The arbiter never generates responses.
- Outside R_DATA, `s_r_ready` is 0. Outside W_RESP, `s_b_ready` is 0. Outside W_DATA, `s_w_valid` is 0.
- `NUM_MST = 1`: grant is always 0 and the pointers are constant.

## Timing
- Reset: both FSMs enter IDLE and `rptr = wptr = 0`. Every valid/ready output is 0 in the cycle after reset is sampled low. Payload outputs are don't-care.
- Reset asserted mid-burst: the FSMs abandon the transaction immediately. Downstream recovery is the system's responsibility.
- Arbitration latency: request in IDLE at cycle t gives `s_*_valid` at t+1. From R_IDLE, the earliest AR handshake is t+1.
- After a handshake of `last`/B at cycle t, the FSM is in IDLE at t+1. The next grant is visible at t+2, so there is one bubble cycle per transaction.
- All forward paths in ADDR/DATA/RESP states are combinational through a mux selected by a registered grant. There is no added beat latency.
- Masters keep payload stable while valid is high (AXI rule). A master dropping valid in ADDR state simply stalls.
- Simultaneous requests: the lowest index at or after the pointer wins, and pointer wrap is modulo `NUM_MST`.
- A master that re-requests immediately after completion loses to any other waiting master.

## Test plan
- **Single read:** master 0 issues AR `addr=0x1c000000`, `len=3`; slave returns 4 beats with `rlast` on the 4th.
  - Required: `m_r_valid[0]` asserts on all 4 beats, `m_r_valid[1]` stays 0, and the FSM is back in R_IDLE one cycle after `rlast`.
- **Round-robin:** masters 0 and 1 both hold AR valid continuously.
  - Required: grant order 0,1,0,1; neither master is granted twice in a row.
- **Concurrent read and write:** master 1 reads while master 0 writes `len=1`, `strb=0xF`.
  - Required: both complete. AW, W and B go only to master 0; R goes only to master 1.
- **Backpressure:** `s_ar_ready`, `s_w_ready` and `m_r_ready` are randomly deasserted for 0–5 cycles.
  - Required: no beat is lost or duplicated, and the data sequence matches the reference memory.
- **Error response:** slave returns `bresp=2'b10`.
  - Required: `m_b_resp=2'b10` is delivered to the granted master and `wptr` advances.
- **Reset mid-transfer:** `rst_n` is pulled low during beat 2 of a 4-beat read.
  - Required: all valid/ready outputs are 0 the next cycle and `rptr=0`.
